mult_result_accumulator: RTL
============================

// Module: mult_result_accumulator
// PURPOSE
//   Downstream stage of the DSP48 multiplier test: consumes one registered product per cycle,
//   sums COUNT consecutive products into a window total and presents it on a valid/ready
//   output. The total is checked against a software sum so DSP inference/placement is verified
//   on silicon. The multiplier has no backpressure, so this block never stalls its input.
// PARAMETERS
//   PROD_W  18  width of incoming product (unsigned)
//   ACC_W   32  width of accumulator and sum_data; must be >= PROD_W
//   COUNT   16  products per window; >= 1. Internal counter width = $clog2(COUNT+1)
// PORTS
//   clk          in   1       system clock (post-BUFG), all logic on rising edge
//   rst_n        in   1       asynchronous active-low reset
//   clear        in   1       synchronous flush of window, output register and flags
//   prod_valid   in   1       prod_data valid this cycle
//   prod_data    in   PROD_W  product from multiplier, unsigned
//   sum_valid    out  1       sum_data holds an unaccepted window total
//   sum_ready    in   1       consumer accepts sum_data when sum_valid && sum_ready
//   sum_data     out  ACC_W   window total (saturated)
//   sum_sat      out  1       window in sum_data saturated; qualified by sum_valid
//   overrun      out  1       sticky: a completed window was dropped
//   window_cnt   out  CNT_W   products accepted in current window, 0..COUNT-1
// BEHAVIOUR
//   Reset (rst_n=0, async): acc=0, window_cnt=0, window sat flag=0, sum_valid=0, sum_data=0,
//     sum_sat=0, overrun=0. Release is synchronised to the clk domain by the top level.
//   Accumulate: on an edge with prod_valid=1 and clear=0, next = acc + zero-extend(prod_data).
//     If the add carries out of ACC_W, next = 2^ACC_W-1 and window sat flag is set.
//     Once saturated, the accumulator stays at max for the rest of the window.
//   Window end: on the edge that accepts the COUNT-th product (window_cnt==COUNT-1):
//     - total = next (includes that product); acc, window_cnt, window sat flag -> 0.
//     - Output register free (sum_valid=0), or freed on the same edge (sum_valid && sum_ready):
//       sum_data=total, sum_sat=sat flag, sum_valid=1. No bubble on simultaneous accept+load.
//     - Output register occupied and not accepted: new total dropped, old sum_data/sum_sat
//       kept unchanged, overrun<=1.
//   Latency: sum_valid is high in the cycle after the edge that samples the last product.
//   Output hold: sum_data, sum_sat, sum_valid stable while sum_valid && !sum_ready.
//     The accept edge clears sum_valid unless a new window loads on the same edge.
//   prod_valid=0: no state change except the output handshake.
//   COUNT==1: every accepted product is a window; window_cnt is constant 0.
//   clear=1: on that edge acc, window_cnt, window sat flag, sum_valid, sum_sat, overrun -> 0.
//     sum_data is not required to clear. clear beats prod_valid and sum_ready on the same
//     edge; the product is discarded.
//   overrun is cleared only by clear or rst_n.
//   rst_n asserted mid-window: partial sum is lost and no sum_valid is produced for it.
//   Arithmetic: all unsigned. No wrap-around on sum_data; saturation only.
// TESTING
//   1 COUNT=4, sum_ready=1; products 10,20,30,40 on 4 consecutive cycles -> sum_valid one
//     cycle later for exactly 1 cycle, sum_data=100, sum_sat=0, window_cnt back to 0.
//   2 ACC_W=19, COUNT=4; 4x 0x3FFFF -> sum_data=524287, sum_sat=1. Next window 1,1,1,1
//     -> sum_data=4, sum_sat=0.
//   3 COUNT=2, sum_ready=0; windows (5,6),(7,8) -> sum_data=11 held, overrun=1. Raise
//     sum_ready -> 11 accepted once. Window (1,2) -> 3, overrun still 1.
//   4 COUNT=2; sum_ready=1 exactly on the edge of 2nd window's last product -> 1st total
//     accepted, 2nd loaded, sum_valid stays 1, overrun=0.
//   5 COUNT=4; products 3,3; clear with prod_valid=1 (value 9); then 1,1,1,1 -> sum_data=4.
//   6 rst_n pulsed low mid-window, asynchronously between edges -> all outputs 0 immediately.
//     Next full window sums correctly.
//   Bench: gaps in prod_valid, random sum_ready; scoreboard compares all totals.

Source files
------------

// File: rtl/mult_result_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_result_accumulator_if
// Purpose  : Product input / window-total output bundle of the accumulator.
// Revision : 1.0 - initial release
// ============================================================================
interface mult_result_accumulator_if #(
    parameter int PROD_W = 18,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 5
);
    logic              clear;
    logic              prod_valid;
    logic [PROD_W-1:0] prod_data;
    logic              sum_valid;
    logic              sum_ready;
    logic [ACC_W-1:0]  sum_data;
    logic              sum_sat;
    logic              overrun;
    logic [CNT_W-1:0]  window_cnt;

    // Master is the multiplier/consumer side, slave is the accumulator.
    modport master (
        output clear, prod_valid, prod_data, sum_ready,
        input  sum_valid, sum_data, sum_sat, overrun, window_cnt
    );

    modport slave (
        input  clear, prod_valid, prod_data, sum_ready,
        output sum_valid, sum_data, sum_sat, overrun, window_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mult_result_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : mult_result_accumulator
// Purpose  : Sums COUNT consecutive products into a saturating window total
//            and presents it on a single-entry valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
module mult_result_accumulator #(
    parameter int PROD_W = 18,
    parameter int ACC_W  = 32,
    parameter int COUNT  = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    mult_result_accumulator_if.slave   bus
);
    localparam int              CNT_W     = $clog2(COUNT + 1);
    localparam logic [ACC_W-1:0] C_ACC_MAX = '1;

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_win_sat;
    logic             r_sum_valid;
    logic [ACC_W-1:0] r_sum_data;
    logic             r_sum_sat;
    logic             r_overrun;

    logic [ACC_W:0]   w_sum_wide;
    logic             w_carry;
    logic [ACC_W-1:0] w_next;
    logic             w_next_sat;
    logic             w_last;
    logic             w_accept;
    logic             w_slot_free;

    // One extra bit catches the carry that triggers saturation.
    assign w_sum_wide  = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod_data};
    assign w_carry     = w_sum_wide[ACC_W];
    assign w_next      = w_carry ? C_ACC_MAX : w_sum_wide[ACC_W-1:0];
    assign w_next_sat  = r_win_sat | w_carry;

    assign w_accept    = r_sum_valid & bus.sum_ready;
    assign w_slot_free = ~r_sum_valid | bus.sum_ready;

    generate
        if (COUNT == 1) begin : g_single
            assign w_last = 1'b1;
        end else begin : g_multi
            localparam logic [CNT_W-1:0] C_LAST = CNT_W'(COUNT - 1);
            assign w_last = (r_cnt == C_LAST);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_win_sat   <= 1'b0;
            r_sum_valid <= 1'b0;
            r_sum_data  <= '0;
            r_sum_sat   <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (bus.clear) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_win_sat   <= 1'b0;
            r_sum_valid <= 1'b0;
            r_sum_sat   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sum_valid <= 1'b0;
            end
            if (bus.prod_valid) begin
                if (w_last) begin
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_win_sat <= 1'b0;
                    // A load on the accept edge overrides the clear above: no bubble.
                    if (w_slot_free) begin
                        r_sum_data  <= w_next;
                        r_sum_sat   <= w_next_sat;
                        r_sum_valid <= 1'b1;
                    end else begin
                        r_overrun   <= 1'b1;
                    end
                end else begin
                    r_acc     <= w_next;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    r_win_sat <= w_next_sat;
                end
            end
        end
    end

    assign bus.sum_valid  = r_sum_valid;
    assign bus.sum_data   = r_sum_data;
    assign bus.sum_sat    = r_sum_sat;
    assign bus.overrun    = r_overrun;
    assign bus.window_cnt = r_cnt;
endmodule
`default_nettype wire
